// File: rtl/xbar_switch_traversal_if.sv
// ----------------------------------------------------------------------------
// xbar_switch_traversal_if
//   Bundles the crossbar's per-VC input side and per-output link side.
//   master : drives flits/valid/mapping and downstream out_ready
//   slave  : the crossbar; returns grants, FIFO heads, errors, counters
//   in_vc_data/in_vc_valid/vc_mapping : head flit, valid, one-hot output
//   in_vc_ready : grant (flit accepted this cycle)
//   out_data/out_valid/out_ready : per-output FIFO head handshake
//   map_err : sticky multi-hot mapping flag per VC
//   flit_cnt : wrapping count of flits popped per output
// ----------------------------------------------------------------------------
interface xbar_switch_traversal_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned NUM_VC     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0][NUM_VC-1:0][DATA_WIDTH-1:0] in_vc_data;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                 in_vc_valid;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][NUM_PORTS-1:0]  vc_mapping;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                 in_vc_ready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]             out_data;
    logic [NUM_PORTS-1:0]                             out_valid;
    logic [NUM_PORTS-1:0]                             out_ready;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                 map_err;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]              flit_cnt;

    modport master (
        output in_vc_data, in_vc_valid, vc_mapping, out_ready,
        input  in_vc_ready, out_data, out_valid, map_err, flit_cnt
    );

    modport slave (
        input  in_vc_data, in_vc_valid, vc_mapping, out_ready,
        output in_vc_ready, out_data, out_valid, map_err, flit_cnt
    );
endinterface

// File: rtl/xbar_switch_traversal.sv
// ----------------------------------------------------------------------------
// xbar_switch_traversal
//   Registered crossbar for router switch traversal. Each output runs a
//   round-robin arbiter over all input VCs whose one-hot route selects it,
//   pushes the winner into a small per-output FIFO and presents the FIFO
//   head with valid/ready toward the link.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of xbar_switch_traversal_if (see interface header)
// ----------------------------------------------------------------------------
module xbar_switch_traversal #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned NUM_VC     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_DEPTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    xbar_switch_traversal_if.slave  bus
);
    localparam int unsigned N  = NUM_PORTS * NUM_VC;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam int unsigned OW = $clog2(OUT_DEPTH + 1);

    logic [NUM_PORTS-1:0][N-1:0]          w_req;
    logic [N-1:0][DATA_WIDTH-1:0]         w_flat_data;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]     w_map_bad;
    logic [NUM_PORTS-1:0]                 w_found;
    logic [NUM_PORTS-1:0][PW-1:0]         w_winner;
    logic [NUM_PORTS-1:0]                 w_pop;
    logic [NUM_PORTS-1:0]                 w_accept;
    logic [N-1:0]                         w_grant;

    logic [NUM_PORTS-1:0][PW-1:0]                         r_ptr;
    logic [NUM_PORTS-1:0][OUT_DEPTH-1:0][DATA_WIDTH-1:0]  r_mem;
    logic [NUM_PORTS-1:0][AW-1:0]                         r_rd;
    logic [NUM_PORTS-1:0][AW-1:0]                         r_wr;
    logic [NUM_PORTS-1:0][OW-1:0]                         r_count;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]                  r_cnt;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                     r_map_err;

    // Requests: only a strictly one-hot mapping requests anything; a
    // multi-hot mapping on a valid VC is flagged instead.
    always_comb begin
        w_req       = '0;
        w_flat_data = '0;
        w_map_bad   = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                w_flat_data[j*NUM_VC+k] = bus.in_vc_data[j][k];
                w_map_bad[j][k] = bus.in_vc_valid[j][k] &&
                                  !$onehot0(bus.vc_mapping[j][k]);
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    w_req[i][j*NUM_VC+k] = bus.in_vc_valid[j][k] &&
                                           bus.vc_mapping[j][k][i] &&
                                           $onehot(bus.vc_mapping[j][k]);
                end
            end
        end
    end

    // Round-robin: first requester at or after ptr, scanning upward with wrap.
    always_comb begin
        w_found  = '0;
        w_winner = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            for (int unsigned off = 0; off < N; off++) begin
                int unsigned idx;
                idx = 32'(r_ptr[i]) + off;
                if (idx >= N) idx = idx - N;
                if (!w_found[i] && w_req[i][idx]) begin
                    w_found[i]  = 1'b1;
                    w_winner[i] = PW'(idx);
                end
            end
        end
    end

    // Accepting into a full FIFO is allowed when the head pops this cycle.
    always_comb begin
        w_pop    = '0;
        w_accept = '0;
        w_grant  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_pop[i]    = (r_count[i] != '0) && bus.out_ready[i];
            w_accept[i] = i_rst_n && w_found[i] &&
                          ((r_count[i] != OW'(OUT_DEPTH)) || w_pop[i]);
            if (w_accept[i]) w_grant[w_winner[i]] = 1'b1;
        end
    end

    always_comb begin
        bus.in_vc_ready = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                bus.in_vc_ready[j][k] = w_grant[j*NUM_VC+k];
            end
        end
    end

    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            bus.out_data[i]  = r_mem[i][r_rd[i]];
            bus.out_valid[i] = (r_count[i] != '0);
        end
    end

    assign bus.map_err  = r_map_err;
    assign bus.flit_cnt = r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_mem     <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_cnt     <= '0;
            r_map_err <= '0;
        end else begin
            r_map_err <= r_map_err | w_map_bad;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_mem[i][r_wr[i]] <= w_flat_data[w_winner[i]];
                    r_wr[i]           <= r_wr[i] + AW'(1);
                    r_ptr[i]          <= (w_winner[i] == PW'(N - 1)) ? '0
                                         : w_winner[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rd[i]  <= r_rd[i] + AW'(1);
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
                case ({w_accept[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + OW'(1);
                    2'b01:   r_count[i] <= r_count[i] - OW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end
endmodule
